// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
// KBD_ASCII_EN enables the scan-code to ASCII table lookup.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DECODE
  } kbd_state_e;

  localparam logic [7:0] KBD_BRK = 8'hF0;
  localparam logic [7:0] KBD_EXT = 8'hE0;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
  } kbd_map_t;

  localparam int KBD_MAP_N = 39;

  localparam kbd_map_t KBD_MAP [KBD_MAP_N] = '{
    '{8'h1C, 8'h61}, '{8'h32, 8'h62}, '{8'h21, 8'h63},
    '{8'h23, 8'h64}, '{8'h24, 8'h65}, '{8'h2B, 8'h66},
    '{8'h34, 8'h67}, '{8'h33, 8'h68}, '{8'h43, 8'h69},
    '{8'h3B, 8'h6A}, '{8'h42, 8'h6B}, '{8'h4B, 8'h6C},
    '{8'h3A, 8'h6D}, '{8'h31, 8'h6E}, '{8'h44, 8'h6F},
    '{8'h4D, 8'h70}, '{8'h15, 8'h71}, '{8'h2D, 8'h72},
    '{8'h1B, 8'h73}, '{8'h2C, 8'h74}, '{8'h3C, 8'h75},
    '{8'h2A, 8'h76}, '{8'h1D, 8'h77}, '{8'h22, 8'h78},
    '{8'h35, 8'h79}, '{8'h1A, 8'h7A},
    '{8'h45, 8'h30}, '{8'h16, 8'h31}, '{8'h1E, 8'h32},
    '{8'h26, 8'h33}, '{8'h25, 8'h34}, '{8'h2E, 8'h35},
    '{8'h36, 8'h36}, '{8'h3D, 8'h37}, '{8'h3E, 8'h38},
    '{8'h46, 8'h39},
    '{8'h29, 8'h20}, '{8'h5A, 8'h0D}, '{8'h66, 8'h08}
  };

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational scan-code (set 2) to ASCII lookup.
// Codes absent from the table map to 0x00.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // search the mapped-code table
  always_comb begin
    ascii = 8'h00;
    for (int i = 0; i < KBD_MAP_N; i++) begin
      if (KBD_MAP[i].code == code) begin
        ascii = KBD_MAP[i].ascii;
      end
    end
  end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// Pops bytes from a PS/2 FIFO and tracks the held key.
// KBD_ASCII_EN: define to include the ASCII lookup.
module kbd_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         kbd_data,
  input  logic               kbd_ready,
  input  logic               kbd_overflow,
  output logic               kbd_nextdata_n,
  output logic [7:0]         key_code,
  output logic [7:0]         key_ascii,
  output logic               key_valid,
  output logic               key_ext,
  output logic               key_press,
  output logic [COUNT_W-1:0] key_count,
  output logic               ovf_sticky
);

  kbd_state_e state;
  kbd_state_e state_nxt;

  logic [7:0] byte_q;
  logic [7:0] ascii_lk;
  logic       brk_pend;
  logic       ext_pend;

  logic is_dec;
  logic is_brk;
  logic is_ext;
  logic is_key;
  logic same;
  logic is_rel;
  logic is_rep;
  logic is_make;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and pop strobe
  always_comb begin
    state_nxt      = state;
    kbd_nextdata_n = 1'b1;
    unique case (state)
      IDLE:    if (kbd_ready) state_nxt = POP;
      POP: begin
        state_nxt      = DECODE;
        kbd_nextdata_n = 1'b0;
      end
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // capture the head byte while popping it
  always_ff @(posedge clk) begin
    if (rst)               byte_q <= 8'h00;
    else if (state == POP) byte_q <= kbd_data;
  end

`ifdef KBD_ASCII_EN
  kbd_scan2ascii u_s2a (
    .code  (byte_q),
    .ascii (ascii_lk)
  );
`else
  assign ascii_lk = 8'h00;
`endif

  assign is_dec  = (state == DECODE);
  assign is_brk  = is_dec && (byte_q == KBD_BRK);
  assign is_ext  = is_dec && (byte_q == KBD_EXT);
  assign is_key  = is_dec && !is_brk && !is_ext;
  assign same    = key_valid && (byte_q == key_code);
  assign is_rel  = is_key && brk_pend;
  assign is_rep  = is_key && !brk_pend && same;
  assign is_make = is_key && !brk_pend && !same;

  // key tracking, prefixes, counter and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code   <= 8'h00;
      key_ascii  <= 8'h00;
      key_valid  <= 1'b0;
      key_ext    <= 1'b0;
      key_press  <= 1'b0;
      key_count  <= '0;
      ovf_sticky <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      key_press  <= 1'b0;
      ovf_sticky <= ovf_sticky | kbd_overflow;
      unique case (1'b1)
        is_brk: brk_pend <= 1'b1;
        is_ext: ext_pend <= 1'b1;
        is_rel: begin
          if (same) key_valid <= 1'b0;
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end
        is_rep: ext_pend <= 1'b0;
        is_make: begin
          key_code  <= byte_q;
          key_ascii <= ext_pend ? 8'h00 : ascii_lk;
          key_ext   <= ext_pend;
          key_valid <= 1'b1;
          key_press <= 1'b1;
          key_count <= key_count + COUNT_W'(1);
          ext_pend  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Scoreboard bench for kbd_scancode_decoder.
// Honours KBD_ASCII_EN in its reference model.
module tb_kbd_scancode_decoder;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    kbd_data = 8'h00;
  logic          kbd_ready = 1'b0;
  logic          kbd_overflow = 1'b0;
  logic          kbd_nextdata_n;
  logic [7:0]    key_code;
  logic [7:0]    key_ascii;
  logic          key_valid;
  logic          key_ext;
  logic          key_press;
  logic [CW-1:0] key_count;
  logic          ovf_sticky;

  always #5 clk = ~clk;

  kbd_scancode_decoder #(.COUNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .key_code       (key_code),
    .key_ascii      (key_ascii),
    .key_valid      (key_valid),
    .key_ext        (key_ext),
    .key_press      (key_press),
    .key_count      (key_count),
    .ovf_sticky     (ovf_sticky)
  );

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       valid;
    logic       ext;
    logic       press;
    logic [7:0] count;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  bit         popm = 0;
  bit         p1 = 0;
  bit         p2 = 0;
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;

  // reference model: what a user expects the keyboard to show
  bit         m_valid, m_ext, m_brk, m_extp;
  logic [7:0] m_code, m_ascii;
  int         m_count;

  logic [7:0] let_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(logic [7:0] c);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == c) r = 8'("a") + 8'(i);
    for (int i = 0; i < 10; i++)
      if (dig_codes[i] == c) r = 8'("0") + 8'(i);
    if (c == 8'h29) r = 8'h20;
    if (c == 8'h5A) r = 8'h0D;
    if (c == 8'h66) r = 8'h08;
`ifndef KBD_ASCII_EN
    r = 8'h00;
`endif
    return r;
  endfunction

  function automatic exp_t model_step(logic [7:0] b);
    exp_t e;
    bit   press = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_extp = 1;
    else if (m_brk) begin
      if (m_valid && b == m_code) m_valid = 0;
      m_brk  = 0;
      m_extp = 0;
    end else if (m_valid && b == m_code) begin
      m_extp = 0;
    end else begin
      m_code  = b;
      m_ext   = m_extp;
      m_ascii = m_extp ? 8'h00 : ref_ascii(b);
      m_valid = 1;
      press   = 1;
      m_count = (m_count + 1) % 256;
      m_extp  = 0;
    end
    e.code  = m_code;
    e.ascii = m_ascii;
    e.valid = m_valid;
    e.ext   = m_ext;
    e.press = press;
    e.count = 8'(m_count);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(logic [7:0] b);
    fq.push_back(b);
    sb.push_back(model_step(b));
  endtask

  task automatic drain(int maxc);
    int c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    #2;
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    m_valid = 0; m_ext = 0; m_brk = 0; m_extp = 0;
    m_code = 8'h00; m_ascii = 8'h00; m_count = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_nextdata_n", kbd_nextdata_n, 1);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_ascii", key_ascii, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_key_press", key_press, 0);
    chk("rst_key_count", key_count, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    tick(1);
    rst = 1'b0;
  endtask

  // FIFO model: head byte presented, popped after the strobe cycle
  always @(negedge clk) begin
    if (rst) begin
      fq.delete();
      popm = 0;
    end else begin
      if (popm && fq.size() > 0) void'(fq.pop_front());
      popm = !kbd_nextdata_n;
    end
    kbd_ready = (fq.size() > 0);
    kbd_data  = (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // monitor: outputs reflect a popped byte two cycles after its strobe
  always @(negedge clk) begin
    if (rst) begin
      p1 = 0;
      p2 = 0;
    end else begin
      if (p2) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("key_code", key_code, mon_e.code);
          chk("key_ascii", key_ascii, mon_e.ascii);
          chk("key_valid", key_valid, mon_e.valid);
          chk("key_ext", key_ext, mon_e.ext);
          chk("key_press", key_press, mon_e.press);
          chk("key_count", key_count, mon_e.count);
        end
      end else begin
        chk("press_idle", key_press, 0);
      end
      p2 = p1;
      p1 = !kbd_nextdata_n;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows[$];
    logic [7:0] pool [5] = '{8'h1C, 8'h32, 8'h16, 8'h29, 8'h5A};
    tick(1);
    do_reset();

    push_byte(8'h1C);
    drain(50);
    chk("s1_count", key_count, 1);
    chk("s1_valid", key_valid, 1);
`ifdef KBD_ASCII_EN
    chk("s1_ascii", key_ascii, 8'h61);
`endif

    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
    drain(100);
    chk("s2_count", key_count, 1);
    chk("s2_valid", key_valid, 0);

    push_byte(8'hE0); push_byte(8'h75);
    drain(50);
    chk("s3_ext", key_ext, 1);
    chk("s3_ascii", key_ascii, 0);
    chk("s3_count", key_count, 2);
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain(50);
    chk("s3_valid", key_valid, 0);

    do_reset();
    for (int i = 0; i < 255; i++) push_byte(i[0] ? 8'h1C : 8'h32);
    drain(2000);
    chk("s4_count_max", key_count, 255);
    push_byte(8'h16);
    drain(50);
    chk("s4_wrap", key_count, 0);
`ifdef KBD_ASCII_EN
    chk("s4_ascii", key_ascii, 8'h31);
`endif

    push_byte(8'h29); push_byte(8'h5A);
    push_byte(8'h66); push_byte(8'h45);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!kbd_nextdata_n) lows.push_back(c);
    end
    tick(1);
    chk("s5_pops", lows.size(), 4);
    for (int i = 1; i < lows.size(); i++)
      chk("s5_gap", lows[i] - lows[i-1], 3);
    drain(50);

    do_reset();
    push_byte(8'hF0);
    drain(50);
    do_reset();
    push_byte(8'h1C);
    drain(50);
    chk("s6_valid", key_valid, 1);
    chk("s6_count", key_count, 1);

    kbd_overflow = 1'b1;
    tick(1);
    kbd_overflow = 1'b0;
    push_byte(8'h29);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("ovf_sticky", ovf_sticky, 1);
    end
    tick(1);
    drain(50);
    chk("ovf_decode", key_count, 2);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) push_byte(8'hF0);
      else if (r == 1) push_byte(8'hE0);
      else if (r <= 5) push_byte(pool[$urandom_range(0, 4)]);
      else if (r == 6) push_byte(8'h75);
      else push_byte(8'($urandom_range(0, 255)));
      tick($urandom_range(0, 3));
      if (i % 150 == 149) do_reset();
    end
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
